// File: rtl/mpu_alu_seq_pkg.sv
// Shared definitions for the sequential MPU ALU: opcodes, flag bit positions, FSM states.
// The flag register is present only when MPU_ALU_SEQ_FLAGS_EN is defined.
package mpu_alu_seq_pkg;

  typedef enum logic [3:0] {
    MPU_OP_NONE = 4'd0,
    MPU_OP_MASK = 4'd1,
    MPU_OP_CMP  = 4'd2,
    MPU_OP_LT   = 4'd3,
    MPU_OP_ADD  = 4'd4,
    MPU_OP_HAMM = 4'd5
  } mpu_op_e;

  localparam int MPU_ALU_SEQ_FLAG_ZERO  = 0;
  localparam int MPU_ALU_SEQ_FLAG_CARRY = 1;
  localparam int MPU_ALU_SEQ_FLAG_LT    = 2;
  localparam int MPU_ALU_SEQ_FLAG_EQ    = 3;
  localparam int MPU_ALU_SEQ_FLAG_UNK   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HAMM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mpu_popcount.sv
// Combinational population count of an N-bit slice; feeds the iterative Hamming step.
module mpu_popcount #(
  parameter int N = 16
) (
  input  logic [N-1:0]       in,
  output logic [$clog2(N):0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{$clog2(N){1'b0}}, in[i]};
    end
  end

endmodule

// File: rtl/mpu_alu_seq.sv
// Handshaked lane-extracting MPU ALU; single-cycle ops plus an iterative Hamming distance.
// Define MPU_ALU_SEQ_FLAGS_EN to build the registered status flags; otherwise flags read 0.
module mpu_alu_seq
  import mpu_alu_seq_pkg::*;
#(
  parameter int W     = 64,
  parameter int CHUNK = 16,
  parameter int SELW  = $clog2(W/8)
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [1:0]      size,
  input  logic [W-1:0]    o0,
  input  logic [W-1:0]    o1,
  input  logic [W-1:0]    o2,
  input  logic [W-1:0]    o3,
  input  logic [SELW-1:0] s0,
  input  logic [SELW-1:0] s1,
  input  logic [SELW-1:0] s2,
  input  logic [SELW-1:0] s3,
  input  logic [SELW-1:0] sres,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    res,
  output logic [7:0]      flags,
  output logic            busy
);

  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int AW     = $clog2(W) + 1;
  localparam int PW     = $clog2(CHUNK) + 1;

  function automatic int unsigned lane_bits(input logic [1:0] sz);
    int unsigned b;
    b = 32'd8 << sz;
    if (b > 32'(W)) b = 32'(W);
    return b;
  endfunction

  // A shift of W or more clears the vector, so a full-width lane yields all ones.
  function automatic logic [W-1:0] lane_mask(input int unsigned b);
    return ~({W{1'b1}} << b);
  endfunction

  function automatic logic [W-1:0] lane_field(input logic [W-1:0] v, input logic [SELW-1:0] sel,
                                              input int unsigned b);
    return (v >> (32'(sel) * b)) & lane_mask(b);
  endfunction

  function automatic logic [W-1:0] place(input logic [W-1:0] r, input int unsigned b,
                                         input logic [SELW-1:0] lane);
    return (r & lane_mask(b)) << (32'(lane) * b);
  endfunction

  state_e          state_q, state_d;
  logic            accept;
  int unsigned     bsize_c;
  logic [W-1:0]    hm_c, f0, f1, f2, f3, r_c, x_c;
  logic [W-1:0]    x_q, res_q;
  logic [AW-1:0]   acc_q, acc_next;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      size_q;
  logic [SELW-1:0] sres_q;
  logic [PW-1:0]   chunk_cnt;
  logic            last_chunk;

  assign accept = in_valid && in_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    bsize_c = lane_bits(size);
    hm_c    = lane_mask(bsize_c);
    f0      = lane_field(o0, s0, bsize_c);
    f1      = lane_field(o1, s1, bsize_c);
    f2      = lane_field(o2, s2, bsize_c);
    f3      = lane_field(o3, s3, bsize_c);
    x_c     = (f1 ^ f2) & f3;
    r_c     = '0;
    case (op)
      MPU_OP_MASK: r_c = W'(((~f0 & ~f1 & hm_c) | (f0 & ~f2)) == '0);
      MPU_OP_CMP:  r_c = W'((f0 & f2) == (f1 & f2));
      MPU_OP_LT:   r_c = W'(f0 < f1);
      MPU_OP_ADD:  r_c = (f1 + f2) & hm_c;
      default:     r_c = '0;
    endcase
  end

  mpu_popcount #(.N(CHUNK)) u_popcount (
    .in  (x_q[CHUNK-1:0]),
    .cnt (chunk_cnt)
  );

  assign acc_next   = acc_q + AW'(chunk_cnt);
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (op == MPU_OP_HAMM) ? ST_HAMM : ST_DONE;
      ST_HAMM: if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !sys_rst;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // HAMM walks x one chunk per cycle from the LSB end; lane size and destination are frozen at accept.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      res_q  <= '0;
      x_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      size_q <= '0;
      sres_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          if (op == MPU_OP_HAMM) begin
            x_q    <= x_c;
            acc_q  <= '0;
            cnt_q  <= '0;
            size_q <= size;
            sres_q <= sres;
          end else begin
            res_q <= place(r_c, bsize_c, sres);
          end
        end
        ST_HAMM: begin
          x_q   <= x_q >> CHUNK;
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_chunk) res_q <= place(W'(acc_next), lane_bits(size_q), sres_q);
        end
        default: ;
      endcase
    end
  end

  assign res = res_q;

`ifdef MPU_ALU_SEQ_FLAGS_EN
  logic [7:0] flags_q;
  logic       lt_q, eq_q, carry_c, unk_c;
  logic [W:0] sum_c;

  always_comb begin
    sum_c   = {1'b0, f1} + {1'b0, f2};
    carry_c = (op == MPU_OP_ADD) && |(sum_c & ((W+1)'(1) << bsize_c));
    unk_c   = (op > MPU_OP_HAMM);
  end

  // Compare flags of a HAMM request are taken at accept and published with its result.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      flags_q <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else if (state_q == ST_IDLE && accept) begin
      if (op == MPU_OP_HAMM) begin
        lt_q <= (f0 < f1);
        eq_q <= (f0 == f1);
      end else begin
        flags_q <= '0;
        flags_q[MPU_ALU_SEQ_FLAG_ZERO]  <= (r_c == '0);
        flags_q[MPU_ALU_SEQ_FLAG_CARRY] <= carry_c;
        flags_q[MPU_ALU_SEQ_FLAG_LT]    <= (f0 < f1);
        flags_q[MPU_ALU_SEQ_FLAG_EQ]    <= (f0 == f1);
        flags_q[MPU_ALU_SEQ_FLAG_UNK]   <= unk_c;
      end
    end else if (state_q == ST_HAMM && last_chunk) begin
      flags_q <= '0;
      flags_q[MPU_ALU_SEQ_FLAG_ZERO] <= (acc_next == '0);
      flags_q[MPU_ALU_SEQ_FLAG_LT]   <= lt_q;
      flags_q[MPU_ALU_SEQ_FLAG_EQ]   <= eq_q;
    end
  end

  assign flags = flags_q;
`else
  assign flags = 8'b0;
`endif

endmodule
